// File: rtl/frame_clear_sequencer_pkg.sv
// Shared types and constants for the voxel GPU frame-clear path.
//   clear_state_t   : sequencer states (IDLE, WRITE, DONE)
//   BYTES_PER_WORD  : byte width of one Avalon write word
//   PIXELS_PER_WORD : RGB565 pixels packed into one write word
//   pixel_t         : one RGB565 pixel
//   cnt_width()     : counter width for a count of n, never below 1 bit
package voxel_gpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } clear_state_t;

  localparam int unsigned BYTES_PER_WORD  = 4;
  localparam int unsigned PIXELS_PER_WORD = 2;

  typedef logic [15:0] pixel_t;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/frame_clear_sequencer_if.sv
// Avalon-MM write-only master bundle used by the frame-clear sequencer.
//   address     : byte address of the write
//   writedata   : 32-bit write word
//   write       : write strobe
//   waitrequest : slave stall; the master holds everything while it is high
interface frame_clear_sequencer_if;

  logic [31:0] address;
  logic [31:0] writedata;
  logic        write;
  logic        waitrequest;

  modport master (
    output address,
    output writedata,
    output write,
    input  waitrequest
  );

  modport slave (
    input  address,
    input  writedata,
    input  write,
    output waitrequest
  );

endinterface

// File: rtl/frame_clear_sequencer_addr_gen.sv
// clear_addr_gen: walks the back buffer in row-major order.
//   clock, reset_n : clock and async active-low reset
//   load           : restart at word 0 of row 0 from base
//   base           : word-aligned byte base address
//   advance        : current word was accepted, step to the next one
//   address        : registered byte address of the current word
//   last           : current word is the final word of the frame
// Row starts are accumulated by adding ROW_STRIDE, and the word address is
// kept as its own register so the bus address never passes through an adder.
module clear_addr_gen
  import voxel_gpu_pkg::*;
#(
  parameter logic [15:0] H_RESOLUTION = 16'd256,
  parameter logic [15:0] V_RESOLUTION = 16'd192,
  parameter logic [31:0] ROW_STRIDE   = 32'd1024
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        load,
  input  logic [31:0] base,
  input  logic        advance,
  output logic [31:0] address,
  output logic        last
);

  localparam int unsigned WORDS_PER_ROW = 32'(H_RESOLUTION) / PIXELS_PER_WORD;
  localparam int unsigned XW = cnt_width(WORDS_PER_ROW);
  localparam int unsigned YW = cnt_width(32'(V_RESOLUTION));
  localparam logic [XW-1:0] X_LAST = XW'(WORDS_PER_ROW - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(32'(V_RESOLUTION) - 1);

  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [31:0]   row_base;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      x        <= '0;
      y        <= '0;
      row_base <= '0;
      address  <= '0;
    end else if (load) begin
      x        <= '0;
      y        <= '0;
      row_base <= base;
      address  <= base;
    end else if (advance) begin
      if (x == X_LAST) begin
        x        <= '0;
        y        <= y + YW'(1);
        row_base <= row_base + ROW_STRIDE;
        address  <= row_base + ROW_STRIDE;
      end else begin
        x        <= x + XW'(1);
        address  <= address + 32'(BYTES_PER_WORD);
      end
    end
  end

  assign last = (x == X_LAST) && (y == Y_LAST);

endmodule

// File: rtl/frame_clear_sequencer.sv
// frame_clear_sequencer: fills the back pixel buffer with one RGB565 colour,
// two pixels per Avalon write, then pulses done.
//   clock, reset_n : clock and async active-low reset
//   start          : one-cycle clear request, honoured only in IDLE
//   back_buffer    : byte base of the buffer (low two bits ignored)
//   clear_color    : RGB565 fill colour
//   busy           : high whenever the sequencer is not IDLE
//   done           : one-cycle pulse after the last write is accepted
//   m1             : Avalon-MM write master, owned while busy
//
// state | meaning
// IDLE  | waiting for start; bus idle
// WRITE | issuing pixel words, holding each until waitrequest drops
// DONE  | single-cycle done pulse, bus idle
module frame_clear_sequencer
  import voxel_gpu_pkg::*;
#(
  parameter logic [15:0] H_RESOLUTION = 16'd256,
  parameter logic [15:0] V_RESOLUTION = 16'd192,
  parameter logic [31:0] ROW_STRIDE   = 32'd1024
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [31:0]              back_buffer,
  input  pixel_t                   clear_color,
  output logic                     busy,
  output logic                     done,
  frame_clear_sequencer_if.master  m1
);

  clear_state_t state;
  logic         accept;
  logic         load;
  logic         last_word;
  logic [31:0]  word_addr;

  // waitrequest only steers next-state decisions; bus outputs are registers.
  assign accept = m1.write && !m1.waitrequest;
  assign load   = (state == IDLE) && start;

  clear_addr_gen #(
    .H_RESOLUTION (H_RESOLUTION),
    .V_RESOLUTION (V_RESOLUTION),
    .ROW_STRIDE   (ROW_STRIDE)
  ) u_addr_gen (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (load),
    .base    (back_buffer & 32'hFFFF_FFFC),
    .advance (accept),
    .address (word_addr),
    .last    (last_word)
  );

  assign m1.address = word_addr;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      m1.write     <= 1'b0;
      m1.writedata <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state        <= WRITE;
            busy         <= 1'b1;
            m1.write     <= 1'b1;
            m1.writedata <= {clear_color, clear_color};
          end
        end
        WRITE: begin
          if (accept && last_word) begin
            state    <= DONE;
            m1.write <= 1'b0;
            done     <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          m1.write <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_clear_sequencer.sv
// Bench for frame_clear_sequencer: three instances (8x2 stride 32, 4x1
// stride 32, default 256x192 stride 1024). Expected writes are pushed into a
// per-instance queue when a clear is requested; a negedge monitor pops and
// compares every accepted write and every done pulse.
module tb_frame_clear_sequencer;

  logic        clock;
  logic        reset_n;
  logic        start_s  [3];
  logic [31:0] base_s   [3];
  logic [15:0] color_s  [3];
  logic        busy_s   [3];
  logic        done_s   [3];
  logic        wait_s   [3];
  logic        rnd_en   [3];
  logic        mon_wr   [3];
  logic [31:0] mon_addr [3];
  logic [31:0] mon_data [3];

  logic [63:0] exp_q [3][$];
  int          exp_done [3];
  int          acc_cnt  [3];
  int          done_cnt [3];
  int          hold_cnt;
  int          n_checks;
  int          n_errors;

  frame_clear_sequencer_if if_a ();
  frame_clear_sequencer_if if_b ();
  frame_clear_sequencer_if if_c ();

  assign if_a.waitrequest = wait_s[0];
  assign if_b.waitrequest = wait_s[1];
  assign if_c.waitrequest = wait_s[2];
  assign mon_wr[0] = if_a.write;  assign mon_addr[0] = if_a.address;  assign mon_data[0] = if_a.writedata;
  assign mon_wr[1] = if_b.write;  assign mon_addr[1] = if_b.address;  assign mon_data[1] = if_b.writedata;
  assign mon_wr[2] = if_c.write;  assign mon_addr[2] = if_c.address;  assign mon_data[2] = if_c.writedata;

  frame_clear_sequencer #(.H_RESOLUTION(16'd8), .V_RESOLUTION(16'd2), .ROW_STRIDE(32'd32)) dut_a (
    .clock(clock), .reset_n(reset_n), .start(start_s[0]), .back_buffer(base_s[0]),
    .clear_color(color_s[0]), .busy(busy_s[0]), .done(done_s[0]), .m1(if_a));

  frame_clear_sequencer #(.H_RESOLUTION(16'd4), .V_RESOLUTION(16'd1), .ROW_STRIDE(32'd32)) dut_b (
    .clock(clock), .reset_n(reset_n), .start(start_s[1]), .back_buffer(base_s[1]),
    .clear_color(color_s[1]), .busy(busy_s[1]), .done(done_s[1]), .m1(if_b));

  frame_clear_sequencer dut_c (
    .clock(clock), .reset_n(reset_n), .start(start_s[2]), .back_buffer(base_s[2]),
    .clear_color(color_s[2]), .busy(busy_s[2]), .done(done_s[2]), .m1(if_c));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Reference model: word (x,y) of a clear lives at aligned_base + y*stride + 4*x.
  task automatic push_frame(input int k, input logic [31:0] base, input logic [15:0] color,
                            input int h, input int v, input logic [31:0] stride);
    logic [31:0] b;
    b = base & 32'hFFFF_FFFC;
    for (int yy = 0; yy < v; yy++)
      for (int xx = 0; xx < h / 2; xx++)
        exp_q[k].push_back({b + 32'(yy) * stride + 32'(4 * xx), color, color});
    exp_done[k]++;
  endtask

  // Called at posedge+2; returns at posedge+2 of the following cycle.
  task automatic pulse_start(input int k, input logic [31:0] base, input logic [15:0] color);
    base_s[k]  = base;
    color_s[k] = color;
    start_s[k] = 1'b1;
    @(posedge clock); #2;
    start_s[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, input int budget);
    int i;
    i = 0;
    while (!done_s[k] && i < budget) begin
      @(posedge clock); #2;
      i++;
    end
    n_checks++;
    if (!done_s[k]) begin
      n_errors++;
      $display("FAIL done_timeout inst=%0d: got no done in %0d cycles, required a done pulse", k, budget);
    end
  endtask

  // Random stall generator, applied at posedge+1 to enabled instances.
  initial begin
    forever begin
      @(posedge clock); #1;
      for (int k = 0; k < 3; k++)
        if (rnd_en[k]) wait_s[k] = ($urandom_range(0, 3) == 0);
    end
  end

  // Scoreboard monitor.
  initial begin
    logic        prev_stall [3];
    logic [31:0] prev_addr  [3];
    logic [31:0] prev_data  [3];
    logic [63:0] e;
    for (int k = 0; k < 3; k++) prev_stall[k] = 1'b0;
    forever begin
      @(negedge clock);
      for (int k = 0; k < 3; k++) begin
        if (!reset_n) begin
          prev_stall[k] = 1'b0;
          continue;
        end
        if (prev_stall[k]) begin
          n_checks++;
          if (!(mon_wr[k] && mon_addr[k] == prev_addr[k] && mon_data[k] == prev_data[k])) begin
            n_errors++;
            $display("FAIL stall_hold inst=%0d: got wr=%0b addr=%h data=%h required wr=1 addr=%h data=%h",
                     k, mon_wr[k], mon_addr[k], mon_data[k], prev_addr[k], prev_data[k]);
          end
        end
        if (k == 0 && mon_wr[0] && mon_addr[0] == 32'h0800_0004) hold_cnt++;
        if (mon_wr[k] && !wait_s[k]) begin
          acc_cnt[k]++;
          n_checks++;
          if (exp_q[k].size() == 0) begin
            n_errors++;
            $display("FAIL unexpected_write inst=%0d: got addr=%h data=%h required no write",
                     k, mon_addr[k], mon_data[k]);
          end else begin
            e = exp_q[k].pop_front();
            if ({mon_addr[k], mon_data[k]} !== e) begin
              n_errors++;
              $display("FAIL write inst=%0d: got addr=%h data=%h required addr=%h data=%h",
                       k, mon_addr[k], mon_data[k], e[63:32], e[31:0]);
            end
          end
        end
        if (done_s[k]) begin
          done_cnt[k]++;
          n_checks++;
          if (exp_q[k].size() != 0 || exp_done[k] == 0) begin
            n_errors++;
            $display("FAIL done_pulse inst=%0d: got done with %0d writes pending and %0d clears open, required 0 pending and 1 open",
                     k, exp_q[k].size(), exp_done[k]);
          end else begin
            exp_done[k]--;
          end
        end
        prev_stall[k] = mon_wr[k] && wait_s[k];
        prev_addr[k]  = mon_addr[k];
        prev_data[k]  = mon_data[k];
      end
    end
  end

  initial begin
    int c0;
    int i;
    logic [31:0] rb;
    logic [15:0] rc;
    n_checks = 0;
    n_errors = 0;
    hold_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      start_s[k] = 1'b0; base_s[k] = '0; color_s[k] = '0; wait_s[k] = 1'b0;
      rnd_en[k] = 1'b0; exp_done[k] = 0; acc_cnt[k] = 0; done_cnt[k] = 0;
    end
    reset_n = 1'b0;
    #3;
    check("reset_busy_a", busy_s[0], 0);
    check("reset_done_a", done_s[0], 0);
    check("reset_write_a", if_a.write, 0);
    check("reset_addr_a", if_a.address, 0);
    check("reset_data_a", if_a.writedata, 0);
    check("reset_write_c", if_c.write, 0);
    #20;
    reset_n = 1'b1;
    @(posedge clock); #2;

    // Basic clear with exact cycle timing.
    push_frame(0, 32'h0800_0000, 16'h1234, 8, 2, 32'd32);
    pulse_start(0, 32'h0800_0000, 16'h1234);
    check("basic_busy_n1", busy_s[0], 1);
    check("basic_write_n1", if_a.write, 1);
    check("basic_first_addr", if_a.address, 32'h0800_0000);
    for (int w = 1; w < 8; w++) begin
      @(posedge clock); #2;
      check("basic_write_run", if_a.write, 1);
    end
    @(posedge clock); #2;
    check("basic_done", done_s[0], 1);
    check("basic_write_in_done", if_a.write, 0);
    check("basic_busy_in_done", busy_s[0], 1);
    @(posedge clock); #2;
    check("basic_busy_after", busy_s[0], 0);
    check("basic_done_once", done_s[0], 0);

    // Stall three cycles on the second word.
    hold_cnt = 0;
    c0 = acc_cnt[0];
    push_frame(0, 32'h0800_0000, 16'h7E0F, 8, 2, 32'd32);
    pulse_start(0, 32'h0800_0000, 16'h7E0F);
    i = 0;
    while (!(if_a.write && if_a.address == 32'h0800_0004) && i < 20) begin
      @(posedge clock); #2;
      i++;
    end
    wait_s[0] = 1'b1;
    repeat (3) @(posedge clock);
    #2;
    wait_s[0] = 1'b0;
    wait_done(0, 50);
    @(posedge clock); #2;
    check("stall_hold_cycles", hold_cnt, 4);
    check("stall_accepted", acc_cnt[0] - c0, 8);

    // start during WRITE and DONE is ignored; start right after DONE is taken.
    push_frame(0, 32'h0800_0000, 16'h5A5A, 8, 2, 32'd32);
    pulse_start(0, 32'h0800_0000, 16'h5A5A);
    @(posedge clock); #2;
    pulse_start(0, 32'h0900_0000, 16'h0BAD);
    wait_done(0, 50);
    pulse_start(0, 32'h0900_0000, 16'h0BAD);
    push_frame(0, 32'h0800_0000, 16'hC3C3, 8, 2, 32'd32);
    pulse_start(0, 32'h0800_0000, 16'hC3C3);
    check("restart_busy", busy_s[0], 1);
    wait_done(0, 50);
    @(posedge clock); #2;

    // Reset after three accepted writes.
    c0 = acc_cnt[0];
    push_frame(0, 32'h0800_0000, 16'hFFFF, 8, 2, 32'd32);
    pulse_start(0, 32'h0800_0000, 16'hFFFF);
    i = 0;
    while (acc_cnt[0] - c0 < 3 && i < 50) begin
      @(posedge clock); #2;
      i++;
    end
    check("rst_three_writes", acc_cnt[0] - c0, 3);
    reset_n = 1'b0;
    exp_q[0].delete();
    exp_done[0] = 0;
    #1;
    check("rst_write_drop", if_a.write, 0);
    check("rst_busy_drop", busy_s[0], 0);
    check("rst_done_low", done_s[0], 0);
    repeat (2) @(posedge clock);
    #2;
    reset_n = 1'b1;
    c0 = acc_cnt[0];
    repeat (10) @(posedge clock);
    #2;
    check("rst_no_writes", acc_cnt[0] - c0, 0);
    check("rst_idle_busy", busy_s[0], 0);

    // Randomised clears with random stalls on the small instance.
    for (int r = 0; r < 3; r++) begin
      rb = $urandom;
      rc = 16'($urandom);
      push_frame(0, rb, rc, 8, 2, 32'd32);
      rnd_en[0] = 1'b1;
      pulse_start(0, rb, rc);
      wait_done(0, 400);
      rnd_en[0] = 1'b0;
      wait_s[0] = 1'b0;
      @(posedge clock); #2;
    end

    // Alignment and 32-bit wrap.
    push_frame(1, 32'hFFFF_FFF3, 16'hF800, 4, 1, 32'd32);
    pulse_start(1, 32'hFFFF_FFF3, 16'hF800);
    wait_done(1, 20);
    @(posedge clock); #2;
    check("wrap_writes", acc_cnt[1], 2);
    check("wrap_dones", done_cnt[1], 1);

    // Full-size frame with random waitrequest.
    rb = $urandom;
    rc = 16'($urandom);
    push_frame(2, rb, rc, 256, 192, 32'd1024);
    rnd_en[2] = 1'b1;
    pulse_start(2, rb, rc);
    wait_done(2, 45000);
    rnd_en[2] = 1'b0;
    wait_s[2] = 1'b0;
    repeat (5) @(posedge clock);
    #2;
    check("full_writes", acc_cnt[2], 24576);
    check("full_dones", done_cnt[2], 1);

    for (int k = 0; k < 3; k++) begin
      check("pending_writes", exp_q[k].size(), 0);
      check("pending_dones", exp_done[k], 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
